// File: rtl/sift_pkg.sv
// Shared SIFT pipeline definitions: system mode codes and line-buffer FSM states.
// LINE_BUFFER_DRAIN_EN adds the DRAIN state used for bottom-border zero padding.
package sift_pkg;

   localparam logic [2:0] SYS_IDLE          = 3'd0;
   localparam logic [2:0] SYS_GAUSSIAN      = 3'd1;
   localparam logic [2:0] SYS_DETECT_FILTER = 3'd2;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
`ifdef LINE_BUFFER_DRAIN_EN
      STREAM = 2'd2,
      DRAIN  = 2'd3
`else
      STREAM = 2'd2
`endif
   } lb_state_t;

endpackage

// File: rtl/line_buffer_row.sv
// One image row register with async reset, sync clear and load enable.
module line_buffer_row #(
   parameter int ROW_W = 5120
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             ld,
   input  logic [ROW_W-1:0] d,
   output logic [ROW_W-1:0] q
);

   logic [ROW_W-1:0] data_d;
   logic [ROW_W-1:0] data_q;

   // sync clear beats load; otherwise hold
   always_comb begin
      data_d = data_q;
      if (clr)
         data_d = '0;
      else if (ld)
         data_d = d;
   end

   // row storage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         data_q <= '0;
      else
         data_q <= data_d;
   end

   assign q = data_q;

endmodule

// File: rtl/line_buffer_bank.sv
// Row buffer feeding the Gaussian and detect/filter engines.
// Gaussian mode: one DEPTH-row shift chain. Detect/filter mode: NUM_SRC+1 two-row chains.
// Optional feature macro: LINE_BUFFER_DRAIN_EN (auto zero-row drain for bottom padding).
//
// state  | meaning
// IDLE   | empty or post-drain, waiting for first push
// FILL   | chain partially occupied
// STREAM | chain full, window valid
// DRAIN  | pushing DEPTH/2 internal zero rows, input blocked
module line_buffer_bank
   import sift_pkg::*;
#(
   parameter int ROW_W   = 5120,
   parameter int NUM_SRC = 4,
   parameter int DEPTH   = 6,
   localparam int ROWS   = 2 * (NUM_SRC + 1),
   localparam int RV_W   = $clog2(ROWS + 1)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [2:0]               buffer_mode,
   input  logic                     buffer_we,
   input  logic                     fill_zero,
   input  logic                     drain,
   input  logic [ROW_W-1:0]         img_data,
   input  logic [NUM_SRC*ROW_W-1:0] blur_data,
   output logic                     push_ready,
   output logic [ROWS*ROW_W-1:0]    buffer_data,
   output logic [RV_W-1:0]          rows_valid,
   output logic                     window_valid,
   output logic                     drain_done
);

   localparam logic [RV_W-1:0] TGT_GAUSS = RV_W'(DEPTH);
   localparam logic [RV_W-1:0] TGT_DF    = RV_W'(2);

   logic [2:0]       mode_q;
   lb_state_t        state_d, state_q;
   logic [RV_W-1:0]  rows_valid_d, rows_valid_q;
   logic             window_valid_d, window_valid_q;

   logic             mode_clr;
   logic             is_gauss;
   logic             is_df;
   logic             ext_push;
   logic             drn_push;
   logic             push;
   logic             push_zero;
   logic [RV_W-1:0]  target;

   logic [ROW_W-1:0] row_q [ROWS];

`ifdef LINE_BUFFER_DRAIN_EN
   localparam int DW = $clog2(DEPTH / 2 + 1);
   localparam logic [DW-1:0] DRN_LEN = DW'(DEPTH / 2);

   logic [DW-1:0]    drain_cnt_d, drain_cnt_q;
   logic             drain_done_d, drain_done_q;
   logic             push_ready_d, push_ready_q;

   assign push_ready = push_ready_q;
   assign drain_done = drain_done_q;
   assign drn_push   = (state_q == DRAIN) && !mode_clr;
`else
   logic unused_drain;

   assign unused_drain = drain;
   assign push_ready   = 1'b1;
   assign drain_done   = 1'b0;
   assign drn_push     = 1'b0;
`endif

   // push qualification; a mode change or SYS_IDLE clears everything that cycle
   always_comb begin
      mode_clr  = (buffer_mode == SYS_IDLE) || (buffer_mode != mode_q);
      is_gauss  = (buffer_mode == SYS_GAUSSIAN);
      is_df     = (buffer_mode == SYS_DETECT_FILTER);
      ext_push  = push_ready && !mode_clr &&
                  ((is_df && buffer_we) || (is_gauss && (buffer_we || fill_zero)));
      push      = ext_push || drn_push;
      push_zero = drn_push || (ext_push && !buffer_we);
      target    = is_gauss ? TGT_GAUSS : TGT_DF;
   end

   // occupancy count and FSM next state
   always_comb begin
      rows_valid_d = rows_valid_q;
      state_d      = state_q;
`ifdef LINE_BUFFER_DRAIN_EN
      drain_cnt_d  = drain_cnt_q;
      drain_done_d = 1'b0;
`endif
      if (mode_clr) begin
         rows_valid_d = '0;
         state_d      = IDLE;
`ifdef LINE_BUFFER_DRAIN_EN
         drain_cnt_d  = '0;
`endif
      end else begin
         if (push && (rows_valid_q < target))
            rows_valid_d = rows_valid_q + 1'b1;
         case (state_q)
            IDLE: begin
               if (push)
                  state_d = (rows_valid_d == target) ? STREAM : FILL;
            end
            FILL: begin
               if (rows_valid_d == target)
                  state_d = STREAM;
            end
            STREAM: ;
`ifdef LINE_BUFFER_DRAIN_EN
            DRAIN: begin
               drain_cnt_d = drain_cnt_q - 1'b1;
               if (drain_cnt_q == DW'(1)) begin
                  drain_done_d = 1'b1;
                  state_d      = IDLE;
               end
            end
`endif
            default: state_d = IDLE;
         endcase
`ifdef LINE_BUFFER_DRAIN_EN
         // a push coinciding with drain is taken above, then the drain starts
         if (drain && is_gauss && ((state_q == FILL) || (state_q == STREAM))) begin
            state_d     = DRAIN;
            drain_cnt_d = DRN_LEN;
         end
`endif
      end
`ifdef LINE_BUFFER_DRAIN_EN
      window_valid_d = (state_d == STREAM) || (state_d == DRAIN);
      push_ready_d   = (state_d != DRAIN);
`else
      window_valid_d = (state_d == STREAM);
`endif
   end

   // control registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q         <= SYS_IDLE;
         state_q        <= IDLE;
         rows_valid_q   <= '0;
         window_valid_q <= 1'b0;
      end else begin
         mode_q         <= buffer_mode;
         state_q        <= state_d;
         rows_valid_q   <= rows_valid_d;
         window_valid_q <= window_valid_d;
      end
   end

`ifdef LINE_BUFFER_DRAIN_EN
   // drain timer and handshake registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drain_cnt_q  <= '0;
         drain_done_q <= 1'b0;
         push_ready_q <= 1'b1;
      end else begin
         drain_cnt_q  <= drain_cnt_d;
         drain_done_q <= drain_done_d;
         push_ready_q <= push_ready_d;
      end
   end
`endif

   assign rows_valid   = rows_valid_q;
   assign window_valid = window_valid_q;

   for (genvar r = 0; r < ROWS; r++) begin : g_row
      localparam bit IN_CHAIN = (r < DEPTH);
      logic [ROW_W-1:0] row_d;

      if (r == 0) begin : g_head
         assign row_d = push_zero ? '0 : img_data;
      end else if ((r % 2) == 1) begin : g_odd
         assign row_d = (is_df || IN_CHAIN) ? row_q[r-1] : '0;
      end else begin : g_even
         assign row_d = is_df    ? blur_data[(r/2-1)*ROW_W +: ROW_W] :
                        IN_CHAIN ? row_q[r-1] : '0;
      end

      line_buffer_row #(.ROW_W(ROW_W)) u_row (
         .clk   (clk),
         .rst_n (rst_n),
         .clr   (mode_clr),
         .ld    (push),
         .d     (row_d),
         .q     (row_q[r])
      );

      assign buffer_data[r*ROW_W +: ROW_W] = row_q[r];
   end

endmodule

// File: doc/line_buffer_bank.md
# line_buffer_bank

Parametrised row buffer between the image/blur SRAMs and the Gaussian and detect/filter engines of the SIFT pipeline. It holds `ROWS` full image rows and has two load schemes. In Gaussian mode it is one shift chain of `DEPTH` rows. In detect/filter mode it is `NUM_SRC+1` two-row chains, one per source. It also tracks row occupancy, raises `window_valid`, and can auto-drain the Gaussian chain with zero rows for bottom-border padding.

## Interface
Parameters:
- `ROW_W`, 5120: bits per row.
- `NUM_SRC`, 4: blur sources in detect/filter mode.
- `DEPTH`, 6: Gaussian chain length; legal range 2..`ROWS`.
- `ROWS`, `2*(NUM_SRC+1)`: derived, not overridable.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `buffer_mode` in 3: `SYS_IDLE`=0, `SYS_GAUSSIAN`=1, `SYS_DETECT_FILTER`=2; other codes hold contents.
- `buffer_we` in 1: push one row this cycle.
- `fill_zero` in 1: push an all-zero row (Gaussian mode only).
- `drain` in 1: start the auto zero-padding sequence (pulse).
- `img_data` in `ROW_W`: image row from SRAM.
- `blur_data` in `NUM_SRC*ROW_W`: source k occupies bits `[k*ROW_W +: ROW_W]`.
- `push_ready` out 1: the block accepts `buffer_we`/`fill_zero`.
- `buffer_data` out `ROWS*ROW_W`: row r occupies bits `[r*ROW_W +: ROW_W]`.
- `rows_valid` out `$clog2(ROWS+1)`: occupied rows in the active chain.
- `window_valid` out 1: the active chain is full.
- `drain_done` out 1: one-cycle pulse at the end of a drain.

## Operation
- FSM states: `IDLE`, `FILL`, `STREAM`, `DRAIN`.
- Any cycle with `buffer_mode==SYS_IDLE`, and any change of `buffer_mode`:
  - all rows, `rows_valid` and outputs are cleared;
  - the FSM returns to `IDLE`.
- A push is `(buffer_we|fill_zero) & push_ready`.
  - `buffer_we` has priority over `fill_zero`.
  - `fill_zero` is ignored in detect/filter mode.
- Gaussian push:
  - row0 loads `img_data`, or 0 for `fill_zero`;
  - row r loads row r-1 for r < `DEPTH`;
  - rows at index `DEPTH` and above hold 0.
- Detect/filter push: row0 loads `img_data`; row 2k+2 loads source k; each odd row 2k+1 loads row 2k.
- Target count: `DEPTH` in Gaussian mode, 2 in detect/filter mode.
- `rows_valid` increments on each push and saturates at the target.
- FSM transitions:
  - `IDLE` to `FILL` on the first push.
  - `FILL` to `STREAM` when `rows_valid` reaches the target.
  - `STREAM` or `FILL` to `DRAIN` on `drain` (Gaussian mode only).
- In `DRAIN`:
  - `push_ready` is 0;
  - `DEPTH/2` zero rows are pushed internally, one per cycle;
  - on the last zero row, `drain_done` pulses and the FSM goes to `IDLE`, keeping contents and `rows_valid`.
- `drain` in `DRAIN` or `IDLE` is ignored.
- A `drain` arriving together with a push takes the push first, then enters `DRAIN`.
- `window_valid = (state==STREAM) || (state==DRAIN)`.

## Timing
- All outputs are registered. A push is visible on `buffer_data` the cycle after the push edge.
- `push_ready` is 1 in every state except `DRAIN`.
- Drain takes exactly `DEPTH/2` cycles after the `drain` edge. `drain_done` is high during the cycle after the last zero push.
- Reset value of every output is 0, except `push_ready`, which resets to 1. Reset mid-drain aborts the drain with no `drain_done`.

## Configuration
- `LINE_BUFFER_DRAIN_EN` defined: `DRAIN` state, the `drain` input and `drain_done` are implemented as above.
- `LINE_BUFFER_DRAIN_EN` undefined:
  - `drain` is ignored;
  - `drain_done` is tied to 0 and `push_ready` is tied to 1;
  - the FSM has only `IDLE`/`FILL`/`STREAM`.

## Structure
- Shared package `sift_pkg`: `SYS_*` mode constants and the `lb_state_t` enum.
- One sub-module, `line_buffer_row`: a `ROW_W` register with async clear, sync clear and load-enable. It is instantiated `ROWS` times with the row muxes generated per index.

## Test plan
Bench parameters: `ROW_W=16`, `NUM_SRC=4`, `DEPTH=6`.
- Reset then 6 Gaussian pushes of 0x0001..0x0006: row0=0x0006 and row5=0x0001; `rows_valid` goes 1..6; `window_valid` rises on the cycle after push 6.
- Detect mode, 2 pushes with img=0xA0/0xA1 and source k=0xB0+k then 0xC0+k: row0=0xA1, row1=0xA0, row2=0xC0, row3=0xB0; `window_valid` rises after the 2nd push.
- Gaussian mode, `buffer_we` and `fill_zero` together with img=0x55: row0=0x55 (write wins). `fill_zero` alone in detect mode: no change.
- Full Gaussian chain, pulse `drain`: `push_ready`=0 for 3 cycles; `buffer_we` in those cycles is ignored; 3 zero rows shift in; `drain_done` pulses once and state returns to `IDLE`.
- `buffer_mode` switched 1→2 mid-fill after 3 pushes: all rows and `rows_valid` are 0 on the next cycle.
- `rst_n` asserted asynchronously mid-drain: outputs are 0 immediately, `push_ready`=1, no `drain_done`.
